// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: buffers ALU commands in a small FIFO and issues them one at a
// time to an external combinational ALU. After a fixed settle time it samples the
// ALU result and returns it with flags and a sequence tag over a valid/ready port.
module alu_cmd_driver #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [2:0]       cmd_sel,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [7:0]       alu_res,
  input  logic             alu_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_res,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // FIFO storage: one entry is {sel, b, a}
  logic [18:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [18:0]      head;

  state_t           state;
  state_t           state_next;
  logic             capture;
  logic             done;
  logic [CW-1:0]    wait_cnt;
  logic [TAG_W-1:0] tag_cnt;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty;

  // FIFO storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_sel, cmd_b, cmd_a};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state and one-cycle control strobes
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand registers, settle counter and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      wait_cnt  <= '0;
      tag_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_res   <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_tag   <= '0;
    end else begin
      if (pop) begin
        alu_a    <= head[7:0];
        alu_b    <= head[15:8];
        alu_sel  <= head[18:16];
        wait_cnt <= CW'(ALU_LAT - 1);
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (capture) begin
        // The ALU leaves carry stale for logic ops, so mask it here
        rsp_res   <= alu_res;
        rsp_carry <= alu_sel[2] ? 1'b0 : alu_c;
        rsp_zero  <= (alu_res == 8'h00);
        rsp_tag   <= tag_cnt;
        tag_cnt   <= tag_cnt + 1'b1;
        rsp_valid <= 1'b1;
      end else if (done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Testbench for alu_cmd_driver: behavioural ALU behind the block, a scoreboard of
// expected responses computed arithmetically, directed and randomized stimulus.
module tb_alu_cmd_driver;
  localparam int DEPTH = 4, ALU_LAT = 1, TAG_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_sel = '0;
  logic [7:0] alu_a, alu_b, alu_res;
  logic [2:0] alu_sel;
  logic alu_c;
  logic rsp_valid, rsp_ready;
  logic [7:0] rsp_res;
  logic rsp_carry, rsp_zero, busy;
  logic [TAG_W-1:0] rsp_tag;

  int checks = 0, errors = 0;
  int cyc = 0;
  int tag_model = 0;
  bit rr_mode = 1'b0, rr_level = 1'b0, gap_chk = 1'b0;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Consumer ready: fixed level or random, applied shortly after each edge
  always @(posedge clk) begin
    #2;
    rsp_ready = rr_mode ? 1'($urandom_range(0, 1)) : rr_level;
  end

  alu_cmd_driver #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_tag(rsp_tag), .busy(busy)
  );

  // Stand-in 8-bit ALU; carry is left stuck high for logic ops
  always_comb begin
    alu_res = 8'h00;
    alu_c   = 1'b1;
    case (alu_sel)
      3'd0: {alu_c, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: {alu_c, alu_res} = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: {alu_c, alu_res} = {alu_a, 1'b0};
      3'd3: {alu_res, alu_c} = {1'b0, alu_a};
      3'd4: alu_res = alu_a & alu_b;
      3'd5: alu_res = alu_a | alu_b;
      3'd6: alu_res = alu_a ^ alu_b;
      default: alu_res = ~alu_a;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected response from operand arithmetic
  function automatic exp_t model(input int a, input int b, input int sel, input int tag);
    exp_t e;
    int r, c;
    c = 0;
    case (sel)
      0: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: begin r = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
      3: begin r = a / 2; c = a % 2; end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: r = 255 - a;
    endcase
    e.res = 8'(r);
    e.c   = 1'(c);
    e.z   = (r == 0);
    e.tag = TAG_W'(tag);
    return e;
  endfunction

  // Response monitor: scoreboard compare, hold stability, handshake spacing
  logic pend = 1'b0;
  logic [31:0] held = '0;
  bit last_gap = 1'b0;
  int last_cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pend = 1'b0;
      last_gap = 1'b0;
    end else begin
      if (pend) begin
        check_eq("hold_valid", rsp_valid, 1);
        check_eq("hold_data", {rsp_res, rsp_carry, rsp_zero, rsp_tag}, held);
      end
      if (rsp_valid && rsp_ready) begin
        check_eq("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("rsp_res", rsp_res, e.res);
          check_eq("rsp_carry", rsp_carry, e.c);
          check_eq("rsp_zero", rsp_zero, e.z);
          check_eq("rsp_tag", rsp_tag, e.tag);
        end
        $display("rsp tag=%0d res=%02h c=%0b z=%0b cyc=%0d", rsp_tag, rsp_res, rsp_carry, rsp_zero, cyc);
        if (gap_chk && last_gap) check_eq("rsp_gap", cyc - last_cyc, 3);
        last_gap = gap_chk;
        last_cyc = cyc;
        pend = 1'b0;
      end else begin
        pend = rsp_valid;
        held = {rsp_res, rsp_carry, rsp_zero, rsp_tag};
      end
    end
  end

  // Present one command and hold it until accepted; returns 1 ns after the accepting edge
  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
    int n = 0;
    bit ok = 1'b0;
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      else n++;
    end
    check_eq("push_accept", ok, 1);
    @(posedge clk);
    if (ok) begin
      exp_q.push_back(model(a, b, sel, tag_model));
      tag_model = (tag_model + 1) % (1 << TAG_W);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rr_level = 1'b1;
    while ((exp_q.size() != 0 || rsp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear immediately
  task automatic reset_mid(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
    check_eq({tag, "_alu_a"}, alu_a, 0);
    check_eq({tag, "_rsp_tag"}, rsp_tag, 0);
    exp_q.delete();
    tag_model = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_alu", {alu_a, alu_b, alu_sel}, 0);
    check_eq("rst_rsp", {rsp_res, rsp_carry, rsp_zero, rsp_tag}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: add FF+01 with exact latency
    push_cmd(8'hFF, 8'h01, 3'd0);
    @(negedge clk);
    check_eq("t1_valid_e0", rsp_valid, 0);
    check_eq("t1_busy", busy, 1);
    @(negedge clk);
    check_eq("t1_alu_ops", {alu_a, alu_b, alu_sel}, {8'hFF, 8'h01, 3'd0});
    check_eq("t1_valid_e1", rsp_valid, 0);
    @(negedge clk);
    check_eq("t1_valid_e2", rsp_valid, 1);
    check_eq("t1_rsp", {rsp_res, rsp_carry, rsp_zero, rsp_tag}, {8'h00, 1'b1, 1'b1, 4'd0});
    drain();

    // 2: sub then shl, in order
    push_cmd(8'h05, 8'h07, 3'd1);
    push_cmd(8'h81, 8'h00, 3'd2);
    drain();

    // 3: and right after a carrying add
    push_cmd(8'hC0, 8'h80, 3'd0);
    push_cmd(8'hF0, 8'h0F, 3'd4);
    drain();

    // 4: back-pressure fills the FIFO, sixth push refused, then drain at full rate
    rr_level = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) push_cmd(8'($urandom), 8'($urandom), 3'($urandom));
    @(negedge clk);
    check_eq("t4_full_ready", cmd_ready, 0);
    check_eq("t4_pending", rsp_valid, 1);
    cmd_a = 8'h11; cmd_b = 8'h22; cmd_sel = 3'd0; cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t4_refused", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    gap_chk = 1'b1;
    drain();
    gap_chk = 1'b0;

    // 5: random traffic with random back-pressure; tags wrap past 15
    rr_mode = 1'b1;
    for (int i = 0; i < 40; i++) push_cmd(8'($urandom), 8'($urandom), 3'($urandom));
    rr_mode = 1'b0;
    drain();

    // 6a: reset while the op is in WAIT
    rr_level = 1'b0;
    push_cmd(8'h12, 8'h34, 3'd0);
    @(posedge clk); #1;
    check_eq("t6a_pre_busy", busy, 1);
    reset_mid("t6a");

    // 6b: reset with a response pending and another op queued
    rr_level = 1'b0;
    push_cmd(8'h01, 8'h02, 3'd0);
    push_cmd(8'h03, 8'h04, 3'd1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6b_pending", rsp_valid, 1);
    @(posedge clk); #1;
    reset_mid("t6b");

    // First op after reset must carry tag 0
    push_cmd(8'h00, 8'h00, 3'd6);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_first_tag", rsp_tag, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
